// File: rtl/picosoc_a2disk_mv_if.sv
// Drive-volume link between the Apple II disk emulation and the a2disk peripheral.
// The peripheral uses the volume modport; the emulation side uses drive.
interface drive_volume_if;
    logic        ready;
    logic        mounted;
    logic        readonly;
    logic [31:0] size;
    logic        ack;
    logic        active;
    logic [31:0] lba;
    logic [5:0]  blk_cnt;
    logic        rd;
    logic        wr;

    modport volume (
        output ready, mounted, readonly, size, ack,
        input  active, lba, blk_cnt, rd, wr
    );

    modport drive (
        input  ready, mounted, readonly, size, ack,
        output active, lba, blk_cnt, rd, wr
    );
endinterface

// File: rtl/picosoc_a2disk_mv.sv
// PicoSoC iomem peripheral bridging NUM_VOLUMES drive volumes to firmware,
// with a per-volume request engine (latch, pending/ack handshake, cancel detect, irq).
module picosoc_a2disk_mv #(
    parameter int NUM_VOLUMES    = 2,
    parameter int CLOCK_SPEED_HZ = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           iomem_valid,
    input  logic [3:0]     iomem_wstrb,
    input  logic [31:0]    iomem_addr,
    input  logic [31:0]    iomem_wdata,
    output logic [31:0]    iomem_rdata,
    output logic           iomem_ready,
    output logic           irq,
    drive_volume_if.volume volumes [NUM_VOLUMES]
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACK
    } state_t;

    logic                   r_ready;
    logic [31:0]            r_rdata;
    logic [NUM_VOLUMES-1:0] r_irq_en;
    logic [NUM_VOLUMES-1:0] r_req_prev;

    state_t                 r_state   [NUM_VOLUMES];
    logic [31:0]            r_size    [NUM_VOLUMES];
    logic [31:0]            r_lba     [NUM_VOLUMES];
    logic [5:0]             r_blk     [NUM_VOLUMES];
    logic [NUM_VOLUMES-1:0] r_vready;
    logic [NUM_VOLUMES-1:0] r_mounted;
    logic [NUM_VOLUMES-1:0] r_readonly;
    logic [NUM_VOLUMES-1:0] r_pend;
    logic [NUM_VOLUMES-1:0] r_ack;
    logic [NUM_VOLUMES-1:0] r_cancel;
    logic [NUM_VOLUMES-1:0] r_rd_l;
    logic [NUM_VOLUMES-1:0] r_wr_l;

    logic [NUM_VOLUMES-1:0] w_req;
    logic [NUM_VOLUMES-1:0] w_rd;
    logic [NUM_VOLUMES-1:0] w_wr;
    logic [NUM_VOLUMES-1:0] w_active;
    logic [31:0]            w_lba     [NUM_VOLUMES];
    logic [5:0]             w_blk     [NUM_VOLUMES];

    logic                   w_acc;
    logic                   w_is_wr;
    logic                   w_is_rd;
    logic                   w_glob;
    logic [2:0]             w_vol;
    logic [3:0]             w_reg;
    logic [NUM_VOLUMES-1:0] w_sel;
    logic [NUM_VOLUMES-1:0] w_done;
    logic [NUM_VOLUMES-1:0] w_cmd_rd;
    logic [31:0]            w_rdata;
    logic                   w_unused;

    for (genvar g = 0; g < NUM_VOLUMES; g++) begin : g_vol
        assign w_rd[g]     = volumes[g].rd;
        assign w_wr[g]     = volumes[g].wr;
        assign w_req[g]    = volumes[g].rd | volumes[g].wr;
        assign w_active[g] = volumes[g].active;
        assign w_lba[g]    = volumes[g].lba;
        assign w_blk[g]    = volumes[g].blk_cnt;

        assign volumes[g].ready    = r_vready[g];
        assign volumes[g].mounted  = r_mounted[g];
        assign volumes[g].readonly = r_readonly[g];
        assign volumes[g].size     = r_size[g];
        assign volumes[g].ack      = r_ack[g];
    end

    // An access is a valid cycle not already being answered; held valid yields every other cycle.
    assign w_acc    = iomem_valid & ~r_ready;
    assign w_is_wr  = w_acc & (|iomem_wstrb);
    assign w_is_rd  = w_acc & ~(|iomem_wstrb);
    assign w_glob   = iomem_addr[9];
    assign w_vol    = iomem_addr[8:6];
    assign w_reg    = iomem_addr[5:2];
    assign w_unused = (^{iomem_addr[31:10], iomem_addr[1:0]}) ^ (CLOCK_SPEED_HZ != 0);

    always_comb begin
        w_sel    = '0;
        w_done   = '0;
        w_cmd_rd = '0;
        for (int unsigned v = 0; v < NUM_VOLUMES; v++) begin
            w_sel[v]    = ~w_glob & (w_vol == 3'(v));
            w_done[v]   = w_is_wr & w_sel[v] & (w_reg == 4'h8) & iomem_wdata[0];
            w_cmd_rd[v] = w_is_rd & w_sel[v] & (w_reg == 4'h7);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_glob) begin
            case (iomem_addr[8:2])
                7'd0:    w_rdata[NUM_VOLUMES-1:0] = r_pend;
                7'd1:    w_rdata[NUM_VOLUMES-1:0] = r_irq_en;
                7'd2:    w_rdata[3:0] = 4'(NUM_VOLUMES);
                default: w_rdata = '0;
            endcase
        end else begin
            for (int unsigned v = 0; v < NUM_VOLUMES; v++) begin
                if (w_sel[v]) begin
                    case (w_reg)
                        4'h0:    w_rdata[0]   = r_vready[v];
                        4'h1:    w_rdata[0]   = w_active[v];
                        4'h2:    w_rdata[0]   = r_mounted[v];
                        4'h3:    w_rdata[0]   = r_readonly[v];
                        4'h4:    w_rdata      = r_size[v];
                        4'h5:    w_rdata      = r_lba[v];
                        4'h6:    w_rdata[5:0] = r_blk[v];
                        4'h7:    w_rdata[4:0] = {r_cancel[v], r_ack[v], r_pend[v],
                                                 r_wr_l[v], r_rd_l[v]};
                        default: w_rdata      = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_irq_en   <= '0;
            r_req_prev <= '0;
            r_vready   <= '0;
            r_mounted  <= '0;
            r_readonly <= '0;
            r_pend     <= '0;
            r_ack      <= '0;
            r_cancel   <= '0;
            r_rd_l     <= '0;
            r_wr_l     <= '0;
            for (int unsigned v = 0; v < NUM_VOLUMES; v++) begin
                r_state[v] <= ST_IDLE;
                r_size[v]  <= '0;
                r_lba[v]   <= '0;
                r_blk[v]   <= '0;
            end
        end else begin
            r_ready    <= iomem_valid & ~r_ready;
            r_rdata    <= w_is_rd ? w_rdata : '0;
            r_req_prev <= w_req;

            if (w_is_wr && w_glob && (iomem_addr[8:2] == 7'd1)) begin
                r_irq_en <= iomem_wdata[NUM_VOLUMES-1:0];
            end

            for (int unsigned v = 0; v < NUM_VOLUMES; v++) begin
                if (w_is_wr && w_sel[v]) begin
                    case (w_reg)
                        4'h0:    r_vready[v]   <= iomem_wdata[0];
                        4'h2:    r_mounted[v]  <= iomem_wdata[0];
                        4'h3:    r_readonly[v] <= iomem_wdata[0];
                        4'h4:    r_size[v]     <= iomem_wdata;
                        default: ;
                    endcase
                end

                // Clear first so a cancel on the same edge overrides it.
                if (w_cmd_rd[v]) begin
                    r_cancel[v] <= 1'b0;
                end

                case (r_state[v])
                    ST_IDLE: begin
                        if (w_req[v] && !r_req_prev[v]) begin
                            r_lba[v]   <= w_lba[v];
                            r_blk[v]   <= w_blk[v];
                            r_rd_l[v]  <= w_rd[v];
                            r_wr_l[v]  <= w_wr[v];
                            r_pend[v]  <= 1'b1;
                            r_state[v] <= ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        if (w_done[v]) begin
                            r_pend[v]  <= 1'b0;
                            r_ack[v]   <= 1'b1;
                            r_state[v] <= ST_ACK;
                        end else if (!w_req[v]) begin
                            r_pend[v]   <= 1'b0;
                            r_cancel[v] <= 1'b1;
                            r_state[v]  <= ST_IDLE;
                        end
                    end
                    ST_ACK: begin
                        if (!w_req[v]) begin
                            r_ack[v]   <= 1'b0;
                            r_state[v] <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_pend[v]  <= 1'b0;
                        r_ack[v]   <= 1'b0;
                        r_state[v] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq         = |(r_pend & r_irq_en);

endmodule

// File: tb/tb_picosoc_a2disk_mv.sv
// Bench for picosoc_a2disk_mv: a 2-volume and an 8-volume instance on a shared bus driver,
// register vectors from a table plus hand-written request/cancel/bus-timing sequences.
module tb_picosoc_a2disk_mv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset   = 1'b1;
    logic        b_valid = 1'b0;
    logic        b_sel8  = 1'b0;
    logic [31:0] b_addr  = '0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_wstrb = '0;

    logic [31:0] rdata2, rdata8, bus_rdata;
    logic        rdy2, rdy8, irq2, irq8, bus_ready;

    logic [1:0]  rd2 = '0, wr2 = '0, act2 = '0;
    logic [31:0] lba2 [2];
    logic [5:0]  blk2 [2];
    logic [1:0]  ack2, vrdy2, mnt2, ro2;
    logic [31:0] size2 [2];

    logic [7:0]  rd8 = '0, wr8 = '0;
    logic [31:0] lba8 [8];
    logic [5:0]  blk8 [8];

    drive_volume_if vol2 [2] ();
    drive_volume_if vol8 [8] ();

    for (genvar g = 0; g < 2; g++) begin : g_v2
        assign vol2[g].rd      = rd2[g];
        assign vol2[g].wr      = wr2[g];
        assign vol2[g].active  = act2[g];
        assign vol2[g].lba     = lba2[g];
        assign vol2[g].blk_cnt = blk2[g];
        assign ack2[g]  = vol2[g].ack;
        assign vrdy2[g] = vol2[g].ready;
        assign mnt2[g]  = vol2[g].mounted;
        assign ro2[g]   = vol2[g].readonly;
        assign size2[g] = vol2[g].size;
    end

    for (genvar g = 0; g < 8; g++) begin : g_v8
        assign vol8[g].rd      = rd8[g];
        assign vol8[g].wr      = wr8[g];
        assign vol8[g].active  = 1'b0;
        assign vol8[g].lba     = lba8[g];
        assign vol8[g].blk_cnt = blk8[g];
    end

    picosoc_a2disk_mv #(.NUM_VOLUMES(2), .CLOCK_SPEED_HZ(12000000)) dut2 (
        .clk(clk), .reset(reset),
        .iomem_valid(b_valid & ~b_sel8), .iomem_wstrb(b_wstrb),
        .iomem_addr(b_addr), .iomem_wdata(b_wdata),
        .iomem_rdata(rdata2), .iomem_ready(rdy2), .irq(irq2),
        .volumes(vol2)
    );

    picosoc_a2disk_mv #(.NUM_VOLUMES(8), .CLOCK_SPEED_HZ(12000000)) dut8 (
        .clk(clk), .reset(reset),
        .iomem_valid(b_valid & b_sel8), .iomem_wstrb(b_wstrb),
        .iomem_addr(b_addr), .iomem_wdata(b_wdata),
        .iomem_rdata(rdata8), .iomem_ready(rdy8), .irq(irq8),
        .volumes(vol8)
    );

    assign bus_ready = b_sel8 ? rdy8 : rdy2;
    assign bus_rdata = b_sel8 ? rdata8 : rdata2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        string       nm;
        bit          s8;
        logic [31:0] addr;
        logic [3:0]  st;
        logic [31:0] wd;
        logic [31:0] exp;
        bit          is_rd;
    } vec_t;
    vec_t vt [$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void add(input string nm, input bit s8, input logic [31:0] a,
                                input logic [3:0] st, input logic [31:0] wd,
                                input logic [31:0] exp, input bit is_rd);
        vec_t e;
        e.nm = nm; e.s8 = s8; e.addr = a; e.st = st; e.wd = wd; e.exp = exp; e.is_rd = is_rd;
        vt.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit s8, input logic [31:0] a, input logic [3:0] st,
                       input logic [31:0] wd, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = '0;
        b_sel8 = s8; b_addr = a; b_wstrb = st; b_wdata = wd; b_valid = 1'b1;
        for (int k = 0; k < 4 && !got; k++) begin
            tick();
            if (bus_ready) begin
                got = 1'b1;
                rd  = bus_rdata;
            end
        end
        b_valid = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout addr=0x%08h: no ready seen, required within 4 cycles", a);
        end
    endtask

    task automatic wr_reg(input bit s8, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(s8, a, 4'hF, wd, dummy);
    endtask

    task automatic rd_chk(input string nm, input bit s8, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] got;
        sb_t e;
        e.nm = nm;
        e.exp = exp;
        sb.push_back(e);
        bus(s8, a, 4'h0, 32'h0, got);
        e = sb.pop_front();
        chk(e.nm, got, e.exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] dummy;
        logic [5:0]  pat;
        int          bad;

        for (int i = 0; i < 2; i++) begin lba2[i] = '0; blk2[i] = '0; end
        for (int i = 0; i < 8; i++) begin lba8[i] = '0; blk8[i] = '0; end

        for (int v = 0; v < 2; v++)
            for (int o = 0; o < 9; o++)
                add($sformatf("rst_v%0d_off%02h", v, o * 4), 1'b0, 32'(v * 64 + o * 4), 4'h0, 32'h0, 32'h0, 1'b1);
        add("rst_info",    1'b0, 32'h208, 4'h0, 32'h0,        32'h2,        1'b1);
        add("rst_pending", 1'b0, 32'h200, 4'h0, 32'h0,        32'h0,        1'b1);
        add("rst_irq_en",  1'b0, 32'h204, 4'h0, 32'h0,        32'h0,        1'b1);
        add("info8",       1'b1, 32'h208, 4'h0, 32'h0,        32'h8,        1'b1);
        add("w_size1",     1'b0, 32'h050, 4'h1, 32'hDEADBEEF, 32'h0,        1'b0);
        add("size1",       1'b0, 32'h050, 4'h0, 32'h0,        32'hDEADBEEF, 1'b1);
        add("w_ready0",    1'b0, 32'h000, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0);
        add("ready0",      1'b0, 32'h000, 4'h0, 32'h0,        32'h1,        1'b1);
        add("w_mounted1",  1'b0, 32'h048, 4'h2, 32'h3,        32'h0,        1'b0);
        add("mounted1",    1'b0, 32'h048, 4'h0, 32'h0,        32'h1,        1'b1);
        add("w_ro0",       1'b0, 32'h00C, 4'h8, 32'h1,        32'h0,        1'b0);
        add("ro0",         1'b0, 32'h00C, 4'h0, 32'h0,        32'h1,        1'b1);
        add("w_irq_en",    1'b0, 32'h204, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0);
        add("irq_en_mask", 1'b0, 32'h204, 4'h0, 32'h0,        32'h3,        1'b1);
        add("w_badvol",    1'b0, 32'h1D0, 4'hF, 32'h55,       32'h0,        1'b0);
        add("badvol_size", 1'b0, 32'h1D0, 4'h0, 32'h0,        32'h0,        1'b1);
        add("badvol_base", 1'b0, 32'h1C0, 4'h0, 32'h0,        32'h0,        1'b1);
        add("w_lba_ro",    1'b0, 32'h014, 4'hF, 32'h77,       32'h0,        1'b0);
        add("lba_ro",      1'b0, 32'h014, 4'h0, 32'h0,        32'h0,        1'b1);
        add("undef_off",   1'b0, 32'h024, 4'h0, 32'h0,        32'h0,        1'b1);
        add("glob_undef",  1'b0, 32'h20C, 4'h0, 32'h0,        32'h0,        1'b1);
        add("w8_size7",    1'b1, 32'h1D0, 4'hF, 32'hCAFE0007, 32'h0,        1'b0);
        add("size7_n8",    1'b1, 32'h1D0, 4'h0, 32'h0,        32'hCAFE0007, 1'b1);

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ack",   32'(ack2), 32'h0);
        chk("rst_irq",   32'(irq2), 32'h0);
        chk("rst_ready", 32'(rdy2), 32'h0);
        chk("rst_rdata", rdata2,    32'h0);

        foreach (vt[i]) begin
            if (vt[i].is_rd) rd_chk(vt[i].nm, vt[i].s8, vt[i].addr, vt[i].exp);
            else             bus(vt[i].s8, vt[i].addr, vt[i].st, vt[i].wd, dummy);
        end
        chk("out_size1",    size2[1],     32'hDEADBEEF);
        chk("out_ready0",   32'(vrdy2[0]), 32'h1);
        chk("out_mounted1", 32'(mnt2[1]),  32'h1);
        chk("out_ro0",      32'(ro2[0]),   32'h1);

        act2[1] = 1'b1;
        rd_chk("active1", 1'b0, 32'h044, 32'h1);
        act2[1] = 1'b0;

        // Read request on volume 0
        wr_reg(1'b0, 32'h204, 32'h1);
        lba2[0] = 32'h1234; blk2[0] = 6'd5; rd2[0] = 1'b1;
        tick();
        chk("req_irq", 32'(irq2), 32'h1);
        lba2[0] = 32'h9999; blk2[0] = 6'd9;
        rd_chk("req_pending", 1'b0, 32'h200, 32'h1);
        rd_chk("req_lba",     1'b0, 32'h014, 32'h1234);
        rd_chk("req_blk",     1'b0, 32'h018, 32'h5);
        rd_chk("req_cmd",     1'b0, 32'h01C, 32'h5);
        wr_reg(1'b0, 32'h020, 32'h1);
        chk("done_ack", 32'(ack2[0]), 32'h1);
        chk("done_irq", 32'(irq2),    32'h0);
        wr_reg(1'b0, 32'h020, 32'h1);
        chk("ack_hold", 32'(ack2[0]), 32'h1);
        rd_chk("ack_cmd", 1'b0, 32'h01C, 32'h9);
        rd2[0] = 1'b0;
        tick();
        chk("ack_release", 32'(ack2[0]), 32'h0);
        rd_chk("idle_cmd", 1'b0, 32'h01C, 32'h1);

        // Cancel on volume 1 with its interrupt masked
        wr_reg(1'b0, 32'h204, 32'h0);
        wr2[1] = 1'b1;
        tick();
        chk("cancel_irq_masked", 32'(irq2), 32'h0);
        rd_chk("cancel_pend", 1'b0, 32'h200, 32'h2);
        wr2[1] = 1'b0;
        tick();
        rd_chk("cancel_pend_clr", 1'b0, 32'h200, 32'h0);
        rd_chk("cancel_cmd1",     1'b0, 32'h05C, 32'h12);
        rd_chk("cancel_cmd2",     1'b0, 32'h05C, 32'h02);

        // Cancel on the same edge as the clearing CMD read keeps the flag
        wr2[1] = 1'b1;
        tick();
        wr2[1] = 1'b0;
        rd_chk("race_cmd1", 1'b0, 32'h05C, 32'h06);
        rd_chk("race_cmd2", 1'b0, 32'h05C, 32'h12);
        rd_chk("race_cmd3", 1'b0, 32'h05C, 32'h02);

        // DONE and rd drop on the same cycle
        tick();
        lba2[0] = 32'h42; rd2[0] = 1'b1;
        tick();
        rd2[0] = 1'b0;
        wr_reg(1'b0, 32'h020, 32'h1);
        chk("race_ack_hi", 32'(ack2[0]), 32'h1);
        tick();
        chk("race_ack_lo", 32'(ack2[0]), 32'h0);
        rd_chk("race_done_cmd", 1'b0, 32'h01C, 32'h1);
        rd_chk("race_done_lba", 1'b0, 32'h014, 32'h42);

        // Reset in the middle of a request
        tick();
        rd2[0] = 1'b1;
        tick();
        wr_reg(1'b0, 32'h020, 32'h1);
        reset = 1'b1; rd2[0] = 1'b0;
        tick();
        chk("midrst_ack", 32'(ack2[0]), 32'h0);
        reset = 1'b0;
        tick();
        rd_chk("midrst_cmd",   1'b0, 32'h01C, 32'h0);
        rd_chk("midrst_ready", 1'b0, 32'h000, 32'h0);

        // Eight-volume instance: independent requests on volumes 3 and 7
        rd8[3] = 1'b1; lba8[3] = 32'h3333;
        wr8[7] = 1'b1; lba8[7] = 32'h7777; blk8[7] = 6'd63;
        tick();
        chk("n8_irq", 32'(irq8), 32'h0);
        rd_chk("n8_pending", 1'b1, 32'h200, 32'h88);
        rd_chk("n8_lba7",    1'b1, 32'h1D4, 32'h7777);
        rd_chk("n8_blk7",    1'b1, 32'h1D8, 32'h3F);
        rd_chk("n8_cmd7",    1'b1, 32'h1DC, 32'h6);
        rd_chk("n8_cmd3",    1'b1, 32'h0DC, 32'h5);
        rd_chk("n8_lba3",    1'b1, 32'h0D4, 32'h3333);

        // Held valid: ready every other cycle, rdata zero between pulses
        tick();
        b_sel8 = 1'b0; b_addr = 32'h208; b_wstrb = 4'h0; b_valid = 1'b1;
        pat = '0;
        bad = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            pat[k-1] = rdy2;
            if (!rdy2 && rdata2 != 32'h0) bad++;
            if (rdy2 && rdata2 != 32'h2) bad++;
            if (k == 5) b_valid = 1'b0;
        end
        chk("hold_valid_ready", 32'(pat), 32'h15);
        chk("hold_valid_rdata", 32'(bad), 32'h0);

        bus(1'b0, 32'h010, 4'h1, 32'hDEADBEEF, dummy);
        chk("wstrb_size_out", size2[0], 32'hDEADBEEF);
        rd_chk("wstrb_size", 1'b0, 32'h010, 32'hDEADBEEF);

        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/picosoc_a2disk_mv.md
# picosoc_a2disk_mv

Parametrised PicoSoC memory-mapped peripheral that bridges NUM_VOLUMES drive volumes between the Apple II disk emulation and PicoSoC firmware. It sits on the PicoSoC iomem bus beside the other picosoc_* peripherals. Each volume has a hardware request engine: it latches the request, tracks it with a pending/ack state machine, releases ack automatically, detects cancellation and raises a maskable interrupt.

## Interface
- NUM_VOLUMES, 2, number of volumes, legal range 1..8
- CLOCK_SPEED_HZ, 0, system clock; informational, unused
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iomem_valid  in  1  bus request
- iomem_wstrb  in  4  byte strobes; any bit set = write, all zero = read
- iomem_addr  in  32  byte address; only [9:2] decoded
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid with iomem_ready
- iomem_ready  out  1  one-cycle completion pulse
- irq  out  1  level interrupt to PicoSoC
- volumes  drive_volume_if.volume  [NUM_VOLUMES]  driven: ready, mounted, readonly, size[31:0], ack; sampled: active, lba[31:0], blk_cnt[5:0], rd, wr

## Operation
- Decode: addr[9]=0 selects per-volume space, with volume v = addr[8:6] and register = addr[5:2]. addr[9]=1 selects global space.
- Per-volume registers (offsets):
  - 0x00 READY RW bit0
  - 0x04 ACTIVE R
  - 0x08 MOUNTED RW bit0
  - 0x0C READONLY RW bit0
  - 0x10 SIZE RW 32b
  - 0x14 LBA R, latched
  - 0x18 BLK_CNT R, latched, zero-extended
  - 0x1C CMD R: bit0 rd latched, bit1 wr latched, bit2 pending, bit3 ack, bit4 cancelled (sticky; cleared by CMD read)
  - 0x20 DONE W: bit0=1 completes the request
- Global registers: 0x200 PENDING R, bitmap [NUM_VOLUMES-1:0]; 0x204 IRQ_EN RW, bitmap; 0x208 INFO R, [3:0]=NUM_VOLUMES.
- Accesses with v>=NUM_VOLUMES, and undefined offsets, read 0. Writes to them and to R registers are ignored. All still complete with ready.
- Byte strobes are ignored: any strobe set performs a full-register write.
- Per-volume FSM (req = rd|wr; req_prev = req registered):
  - IDLE:
    - req & !req_prev → latch lba, blk_cnt, rd, wr; go to PEND.
    - If rd and wr are both high, both latch bits are set.
  - PEND:
    - DONE write with bit0=1 → go to ACK.
    - Else if req=0 → set cancelled, go to IDLE.
    - DONE wins over a simultaneous req drop.
  - ACK: ack=1. When req=0 → ack=0, go to IDLE. DONE writes are ignored.
- pending bit = (state==PEND). ack = (state==ACK). irq = |(pending & IRQ_EN).
- A req already high on leaving ACK or cancel does not retrigger; a new rising edge is required.
- Latched LBA, BLK_CNT and CMD bits 0-1 hold until the next capture.
- Writing READY or MOUNTED does not affect the FSM.

## Timing
- Reset values:
  - iomem_ready=0, iomem_rdata=0, irq=0.
  - All volumes: ready, mounted, readonly, size, ack all 0.
  - All FSMs in IDLE; latches, cancelled and IRQ_EN all 0; req_prev=0.
- Reset mid-request: the FSM returns to IDLE and ack drops the cycle after reset. No cancelled flag is set.
- Bus: iomem_ready is asserted the cycle after valid, computed as ready <= valid & !ready. rdata is registered and is 0 whenever ready=0. A held valid gets a response every other cycle.
- Read data reflects register state as of the valid cycle.
- A write takes effect on the cycle iomem_ready is asserted.
- Request edge on cycle t → state PEND, pending and irq high at t+1. Latched values are the inputs sampled at t.
- DONE accepted at cycle w → ack=1 and pending=0 at w+1; irq falls at w+1.
- req low at cycle r in ACK → ack=0 at r+1. Minimum ack width is 1 cycle.
- CMD read clears cancelled at the ready cycle. A cancel on the same cycle as the clear wins (flag stays set).

## Test plan
- Reset values: assert reset for 2 cycles, then read every register of volumes 0 and 1 plus INFO → all 0 except INFO=2; ack=0, irq=0.
- Read request: set IRQ_EN=1; drive lba=0x1234, blk_cnt=5, rd=1 on vol0 → next cycle irq=1, PENDING=0x1, LBA=0x1234, BLK_CNT=5, CMD=0x5. Write DONE=1 → ack=1, irq=0. Drop rd → ack=0 one cycle later, CMD=0x1.
- Cancel: vol1 wr=1 with IRQ_EN=0 → PENDING=0x2, irq stays 0. Drop wr before DONE → PENDING=0. First CMD read returns bit4=1; second read returns bit4=0.
- Same-cycle DONE write and rd drop on vol0 → ack high for exactly 1 cycle, cancelled=0.
- NUM_VOLUMES=8: independent requests on vol3 and vol7 → PENDING=0x88. Read at v=7 is valid. With NUM_VOLUMES=2, address 0x1C0 reads 0 and writes are ignored.
- Bus protocol: hold valid for 6 cycles → ready pulses on cycles 2, 4, 6. Write SIZE=0xDEADBEEF with wstrb=0x1 → size=0xDEADBEEF.
